// File: rtl/neuron_sequencer_if.sv
// Operand stream and result stream between the layer scheduler and the
// neuron sequencer. The scheduler side uses master, the sequencer uses slave.
interface neuron_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_x;
    logic [DATA_W-1:0] in_w;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sat;

    modport master (
        output in_valid, in_x, in_w, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_x, in_w, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/neuron_sequencer.sv
// Neuron evaluation sequencer: accumulates bias + sum(x*w) in fixed point,
// hands the saturated sum to the external activation unit, captures its
// result and offers it on a valid/ready output.
package neuron_sequencer_pkg;
    typedef enum logic [1:0] {
        ACT_RELU  = 2'd0,
        ACT_IDENT = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLIP  = 2'd3
    } act_func_t;
endpackage

// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; accumulator holds last value
// ST_ACCUM | accepting (x, w) beats until n have been consumed
// ST_ACT   | single cycle: activation unit output captured
// ST_OUT   | result offered on out_valid until out_ready
module neuron_sequencer
    import neuron_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40,
    parameter int N_MAX  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(N_MAX):0]     num_inputs,
    input  act_func_t                  act_cfg,
    input  logic [DATA_W-1:0]          bias,
    output logic                       busy,
    output act_func_t                  act_sel,
    output logic [DATA_W-1:0]          act_sum,
    input  logic [DATA_W-1:0]          act_result,
    neuron_sequencer_if.slave          bus
);

    localparam int CNT_W = $clog2(N_MAX) + 1;
    localparam logic [CNT_W-1:0] N_MAX_C = CNT_W'(N_MAX);

    // Clamp limits expressed at accumulator width so the compare is exact.
    localparam logic signed [ACC_W-1:0] SUM_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SUM_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_ACT   = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          n_r;
    act_func_t                 sel_r;
    logic                      busy_r;
    logic                      in_ready_r;
    logic                      out_valid_r;
    logic [DATA_W-1:0]         out_data_r;
    logic                      out_sat_r;

    logic [CNT_W-1:0]          n_eff;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum_shift;
    logic                      sat_hi;
    logic                      sat_lo;
    logic                      beat;

    assign n_eff    = (num_inputs > N_MAX_C) ? N_MAX_C : num_inputs;
    assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};

    // Both operands widened first so the product is the exact 2*DATA_W result.
    assign prod     = $signed({{DATA_W{bus.in_x[DATA_W-1]}}, bus.in_x})
                    * $signed({{DATA_W{bus.in_w[DATA_W-1]}}, bus.in_w});
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // Arithmetic shift drops the fraction, rounding toward minus infinity.
    assign sum_shift = acc >>> FRAC_W;
    assign sat_hi    = (sum_shift > SUM_MAX);
    assign sat_lo    = (sum_shift < SUM_MIN);

    assign beat = bus.in_valid && in_ready_r;

    // Saturating narrowing of the shifted accumulator onto the activation bus.
    always_comb begin
        act_sum = sum_shift[DATA_W-1:0];
        if (sat_hi) begin
            act_sum = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sat_lo) begin
            act_sum = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    // Sequencer FSM; every externally visible control bit is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            acc         <= '0;
            cnt         <= '0;
            n_r         <= '0;
            sel_r       <= ACT_RELU;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sat_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc    <= bias_ext;
                        cnt    <= '0;
                        n_r    <= n_eff;
                        sel_r  <= act_cfg;
                        busy_r <= 1'b1;
                        if (n_eff != '0) begin
                            state      <= ST_ACCUM;
                            in_ready_r <= 1'b1;
                        end else begin
                            state <= ST_ACT;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == n_r - CNT_W'(1)) begin
                            state      <= ST_ACT;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                ST_ACT: begin
                    out_data_r  <= act_result;
                    out_sat_r   <= sat_hi | sat_lo;
                    out_valid_r <= 1'b1;
                    state       <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign act_sel       = sel_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sat   = out_sat_r;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer: directed cases plus randomized
// evaluations compared against an integer-arithmetic reference model.
module tb_neuron_sequencer;
    import neuron_sequencer_pkg::*;

    localparam int N_MAX = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  num_inputs;
    act_func_t   act_cfg;
    logic [15:0] bias;
    logic        busy;
    act_func_t   act_sel;
    logic [15:0] act_sum;
    logic [15:0] act_result;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] xs [32];
    logic [15:0] ws [32];

    neuron_sequencer_if #(.DATA_W(16)) bus ();

    neuron_sequencer #(
        .DATA_W(16), .FRAC_W(8), .ACC_W(40), .N_MAX(N_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_inputs (num_inputs),
        .act_cfg    (act_cfg),
        .bias       (bias),
        .busy       (busy),
        .act_sel    (act_sel),
        .act_sum    (act_sum),
        .act_result (act_result),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external activation unit.
    function automatic logic [15:0] act_model(input logic [15:0] s, input act_func_t sel);
        case (sel)
            ACT_RELU:  return s[15] ? 16'h0000 : s;
            ACT_IDENT: return s;
            ACT_LEAKY: return s[15] ? 16'($signed(s) >>> 3) : s;
            default:   return ($signed(s) > 256)  ? 16'h0100 :
                              ($signed(s) < -256) ? 16'hFF00 : s;
        endcase
    endfunction

    assign act_result = act_model(act_sum, act_sel);

    function automatic longint floor_div256(input longint v);
        if (v >= 0) return v / 256;
        return -((-v + 255) / 256);
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete evaluation: start, feed beats, wait for result, backpressure, handshake.
    task automatic run_eval(input int nreq, input logic [15:0] b, input act_func_t sel,
                            input int gap, input int rdy_wait, input bit chk_lat,
                            output logic [15:0] obs);
        int     n, taken, cyc;
        longint sum, s;
        logic [15:0] exp_sum, exp_out;
        bit     exp_sat, hs;

        n   = (nreq > N_MAX) ? N_MAX : nreq;
        sum = longint'($signed(b)) * 256;
        obs = '0;

        start = 1'b1; num_inputs = 5'(nreq); bias = b; act_cfg = sel;
        @(posedge clk); #1;
        start = 1'b0;
        bias = 16'($urandom); act_cfg = act_func_t'($urandom_range(0, 3));
        num_inputs = 5'($urandom_range(0, 31));
        cyc = 1; taken = 0;
        check_val("busy_after_start", busy, 1);

        while (!bus.out_valid && cyc < 300) begin
            if (taken < n) begin
                bus.in_valid = ((cyc % (gap + 1)) == 0);
                bus.in_x = xs[taken];
                bus.in_w = ws[taken];
            end else begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_x = 16'($urandom);
                bus.in_w = 16'($urandom);
            end
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                if (taken < n)
                    sum += longint'($signed(xs[taken])) * longint'($signed(ws[taken]));
                taken++;
            end
        end
        if (!bus.out_valid) begin
            check_val("out_valid_timeout", bus.out_valid, 1);
            bus.in_valid = 1'b0;
            return;
        end

        s = floor_div256(sum);
        exp_sat = (s > 32767) || (s < -32768);
        if (s > 32767)       exp_sum = 16'h7FFF;
        else if (s < -32768) exp_sum = 16'h8000;
        else                 exp_sum = 16'(s);
        exp_out = act_model(exp_sum, sel);
        obs = bus.out_data;

        if (chk_lat) check_val("latency", cyc, n + 2);
        check_val("act_sum", act_sum, exp_sum);
        check_val("out_data", bus.out_data, exp_out);
        check_val("out_sat", bus.out_sat, exp_sat);
        check_val("act_sel", act_sel, sel);
        check_val("in_ready_in_out", bus.in_ready, 0);

        for (int k = 0; k < rdy_wait; k++) begin
            start = (k == 0);
            bus.in_valid = 1'($urandom_range(0, 1));
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) taken++;
            check_val("hold_valid", bus.out_valid, 1);
            check_val("hold_data", bus.out_data, exp_out);
            check_val("hold_busy", busy, 1);
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_val("valid_after_hs", bus.out_valid, 0);
        check_val("busy_after_hs", busy, 0);
        check_val("beats_taken", taken, n);
        @(posedge clk); #1;
        check_val("start_not_queued", busy, 0);
    endtask

    logic [15:0] obs;

    initial begin
        rst_n = 1'b0; start = 1'b0; num_inputs = '0; act_cfg = ACT_IDENT; bias = '0;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_w = '0; bus.out_ready = 1'b0;
        #3;
        check_val("rst_busy", busy, 0);
        check_val("rst_in_ready", bus.in_ready, 0);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_sat", bus.out_sat, 0);
        check_val("rst_out_data", bus.out_data, 0);
        check_val("rst_act_sum", act_sum, 0);
        check_val("rst_act_sel", act_sel, ACT_RELU);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic accumulate, ReLU.
        for (int i = 0; i < 3; i++) begin xs[i] = 16'h0100; ws[i] = 16'h0200; end
        run_eval(3, 16'h0080, ACT_RELU, 0, 0, 1, obs);
        check_val("basic_const", obs, 16'h0680);

        // Negative sum, ReLU then identity.
        xs[0] = 16'hFF00; ws[0] = 16'h0300;
        run_eval(1, 16'h0000, ACT_RELU, 0, 0, 1, obs);
        check_val("neg_relu_const", obs, 16'h0000);
        run_eval(1, 16'h0000, ACT_IDENT, 0, 0, 1, obs);
        check_val("neg_ident_const", obs, 16'hFD00);

        // Positive and negative saturation.
        for (int i = 0; i < 4; i++) begin xs[i] = 16'h7FFF; ws[i] = 16'h7FFF; end
        run_eval(4, 16'h0000, ACT_IDENT, 0, 0, 1, obs);
        check_val("sat_pos_const", obs, 16'h7FFF);
        check_val("sat_pos_flag", bus.out_sat, 1);
        for (int i = 0; i < 4; i++) begin xs[i] = 16'h8000; ws[i] = 16'h7FFF; end
        run_eval(4, 16'h0000, ACT_IDENT, 0, 0, 1, obs);
        check_val("sat_neg_const", obs, 16'h8000);
        check_val("sat_neg_flag", bus.out_sat, 1);

        // Gapped beats, output backpressure, start pulsed in OUT.
        xs[0] = 16'h0180; ws[0] = 16'h0100; xs[1] = 16'hFFC0; ws[1] = 16'h0200;
        run_eval(2, 16'h0010, ACT_IDENT, 3, 5, 0, obs);
        check_val("stall_const", obs, 16'h0110);

        // Zero inputs.
        run_eval(0, 16'h0140, ACT_IDENT, 0, 0, 1, obs);
        check_val("n0_const", obs, 16'h0140);

        // Over-length request clamps to N_MAX beats.
        for (int i = 0; i < 20; i++) begin
            xs[i] = 16'($urandom_range(0, 16'h0300)) - 16'h0180;
            ws[i] = 16'($urandom_range(0, 16'h0300)) - 16'h0180;
        end
        run_eval(N_MAX + 3, 16'h0000, ACT_IDENT, 0, 2, 1, obs);

        // Reset in the middle of accumulation.
        start = 1'b1; num_inputs = 5'd5; bias = 16'h1234; act_cfg = ACT_LEAKY;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_x = 16'h0400; bus.in_w = 16'h0300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_in_ready", bus.in_ready, 0);
        check_val("mid_rst_out_valid", bus.out_valid, 0);
        check_val("mid_rst_act_sum", act_sum, 0);
        check_val("mid_rst_act_sel", act_sel, ACT_RELU);
        check_val("mid_rst_out_data", bus.out_data, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xs[0] = 16'h0100; ws[0] = 16'h0100;
        run_eval(1, 16'h0000, ACT_IDENT, 0, 0, 1, obs);
        check_val("post_rst_const", obs, 16'h0100);

        // Randomized evaluations.
        for (int t = 0; t < 40; t++) begin
            int nreq, gap, rw;
            act_func_t sel;
            nreq = $urandom_range(0, N_MAX + 3);
            gap  = $urandom_range(0, 2);
            rw   = $urandom_range(0, 3);
            sel  = act_func_t'($urandom_range(0, 3));
            for (int i = 0; i < 20; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    xs[i] = 16'($urandom); ws[i] = 16'($urandom);
                end else begin
                    xs[i] = 16'($urandom_range(0, 16'h0800)) - 16'h0400;
                    ws[i] = 16'($urandom_range(0, 16'h0800)) - 16'h0400;
                end
            end
            run_eval(nreq, 16'($urandom), sel, gap, rw, (gap == 0), obs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_sequencer.md
# neuron_sequencer

Controller that sequences one neuron evaluation over the shared activation datapath. It accepts a start command and a fixed-point configuration, streams `num_inputs` (x, w) pairs through a valid/ready port, and accumulates bias + Σ x·w. It then drives the saturated sum and the latched activation selector to the external combinational activation unit, captures the result, and presents it on a valid/ready output. It sits between the layer scheduler (command/operand source) and the activation unit (`act_func`-selected).

## Interface
- `DATA_W`, 16: operand, bias, sum and result width; signed fixed point.
- `FRAC_W`, 8: fractional bits of every DATA_W value (default Q8.8).
- `ACC_W`, 40: accumulator width; must satisfy ACC_W ≥ 2·DATA_W + clog2(N_MAX) + 1.
- `N_MAX`, 16: maximum inputs per evaluation.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: command strobe; honoured only in IDLE.
- `num_inputs` in clog2(N_MAX)+1: number of (x, w) beats; sampled on start.
- `act_cfg` in act_func: activation selector; latched on start.
- `bias` in DATA_W: signed bias; sampled on start.
- `busy` out 1: high in every state except IDLE.
- `in_valid` / `in_ready` in / out 1: operand handshake.
- `in_x`, `in_w` in DATA_W each: signed operands.
- `act_sel` out act_func: latched selector to the activation unit.
- `act_sum` out DATA_W: saturated sum to the activation unit.
- `act_result` in DATA_W: combinational result from the activation unit.
- `out_valid` / `out_ready` out / in 1: result handshake.
- `out_data` out DATA_W: captured activation result.
- `out_sat` out 1: act_sum was saturated for this result.

## Operation
- States: IDLE → ACCUM → ACT → OUT → IDLE.
- IDLE, start=1:
  - acc ← sign-extended bias <<< FRAC_W.
  - cnt ← 0; latch act_cfg.
  - n ← min(num_inputs, N_MAX).
  - Go to ACCUM if n>0, else directly to ACT.
- ACCUM:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: acc ← acc + sext(in_x·in_w) as a full 2·DATA_W signed product; cnt++.
  - The beat with cnt==n−1 moves to ACT.
  - Beats with in_valid=0 stall without limit.
- ACT, exactly one cycle:
  - s = acc >>> FRAC_W (arithmetic shift, truncation toward −∞).
  - act_sum = s clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; sat = clamp applied.
  - Registers capture out_data ← act_result and out_sat ← sat.
  - Go to OUT.
- OUT: out_valid=1; out_data and out_sat are held stable until out_ready=1, then go to IDLE.
- start is ignored when not in IDLE. It is not queued.
- act_sel always reflects the latched selector. act_sum is driven from acc in all states; the activation unit's output is consumed only in ACT.
- Accumulator never wraps, given the ACC_W rule.
- Reset, including mid-operation: go to IDLE asynchronously and discard any partial accumulation.

## Timing
- Reset values:
  - busy, in_ready, out_valid, out_sat = 0.
  - out_data = 0.
  - acc = 0, so act_sum = 0.
  - act_sel = first act_func enumerator.
- Start accepted at edge 0. ACCUM is active from cycle 1.
- With in_valid held high, beats land on cycles 1..n, ACT is cycle n+1, and out_valid rises at cycle n+2.
- For n=0, ACT is cycle 1 and out_valid is at cycle 2.
- With out_ready high when out_valid rises, the handshake completes that cycle. IDLE follows, and the next start can be accepted one cycle later.
- in_ready is low in ACT and OUT. Operand beats offered then are not consumed.
- No combinational path from in_valid or out_ready to in_ready, out_valid or busy.

## Test plan
- Basic accumulate with a ReLU activation model:
  - Stimulus: Q8.8, n=3, bias=0x0080; x=0x0100, w=0x0200 each beat; in_valid constant.
  - Response: act_sum=0x0680; out_data=0x0680 at cycle 5; out_sat=0.
- Negative sum with ReLU model:
  - Stimulus: n=1, bias=0, x=0xFF00, w=0x0300.
  - Response: act_sum=0xFD00, out_data=0x0000.
  - Same with the identity selector: out_data=0xFD00.
- Saturation:
  - Stimulus: n=4, x=w=0x7FFF.
  - Response: act_sum=0x7FFF, out_sat=1.
  - Stimulus: x=0x8000, w=0x7FFF.
  - Response: act_sum=0x8000, out_sat=1.
- Stalls and backpressure:
  - Stimulus: n=2 with in_valid gapped 3 cycles between beats; out_ready low 5 cycles; start pulsed during OUT.
  - Response: out_data stable; start ignored; busy high until handshake; single result emitted.
- Boundaries:
  - n=0, bias=0x0140: out_data=0x0140 at cycle 2.
  - num_inputs=N_MAX+3: exactly N_MAX beats consumed.
- Reset mid-ACCUM:
  - Stimulus: rst_n low after 2 of 5 beats.
  - Response: outputs return to reset values immediately. A new start with n=1, x=0x0100, w=0x0100, bias=0 yields out_data=0x0100, showing no residue.
